usb_upstream_arbiter: RTL

Sequences the single host-facing transceiver among NUM_USB_DEVICES downstream response PISOs.
- Grants exactly one device PISO at a time, round-robin, and holds the grant for a whole packet (through piso_data_last).
- Enforces an inter-packet gap, then releases.
- Recovers from a stalled PISO with a watchdog timeout.
- Replaces the free-running combinational select in front of the upstream transceiver.

---
 rtl/usb_upstream_arbiter_pkg.sv | 23 ++
 rtl/usb_upstream_arbiter_if.sv | 35 +++
 rtl/usb_rr_priority_picker.sv | 43 ++++
 rtl/usb_upstream_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/usb_upstream_arbiter_pkg.sv
// Shared widths, state encodings and width helpers for the upstream
// transceiver arbiter.
`ifndef WIDTH_TO_RANGE
`define WIDTH_TO_RANGE(w) ((w)-1):0
`endif
`ifndef CLOG2_WIDTH
`define CLOG2_WIDTH(n) (((n) <= 1) ? 1 : $clog2(n))
`endif

package usb_upstream_arbiter_pkg;

  localparam int REQUEST_SERIAL_DATA_TYPE_WIDTH = 2;
  localparam int RT_W = REQUEST_SERIAL_DATA_TYPE_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_upstream_arbiter_if.sv
// Bundle of PISO-side and transceiver-side handshake signals around the
// upstream arbiter; slave is the arbiter's view, master the surroundings'.
interface usb_upstream_arbiter_if
  import usb_upstream_arbiter_pkg::*;
#(
  parameter int NUM_USB_DEVICES = 2,
  parameter int RT_W_P          = RT_W
);
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]        piso_serial_data_avail;
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]        piso_data_out;
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]        piso_data_val;
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]        piso_data_last;
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]        piso_request_serial_data;
  logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES*RT_W_P)] piso_request_serial_data_type;
  logic                                           tr_request_serial_data;
  logic [`WIDTH_TO_RANGE(RT_W_P)]                 tr_request_serial_data_type;
  logic                                           tr_data_out;
  logic                                           tr_data_val;
  logic                                           tr_data_last;
  logic                                           tr_serial_data_avail;

  modport slave (
    input  piso_serial_data_avail, piso_data_out, piso_data_val, piso_data_last,
    input  tr_request_serial_data, tr_request_serial_data_type,
    output piso_request_serial_data, piso_request_serial_data_type,
    output tr_data_out, tr_data_val, tr_data_last, tr_serial_data_avail
  );

  modport master (
    output piso_serial_data_avail, piso_data_out, piso_data_val, piso_data_last,
    output tr_request_serial_data, tr_request_serial_data_type,
    input  piso_request_serial_data, piso_request_serial_data_type,
    input  tr_data_out, tr_data_val, tr_data_last, tr_serial_data_avail
  );
endinterface

// File: rtl/usb_rr_priority_picker.sv
// Combinational round-robin first-set finder: searches req upward from ptr
// with wrap-around and returns the winner as one-hot and as an index.
module usb_rr_priority_picker
  import usb_upstream_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IDX_W:0] offset;
  logic [IDX_W:0] sum;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);

  always_comb begin
    offset = '0;
    any    = 1'b0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = (IDX_W+1)'(i);
        any    = 1'b1;
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= (IDX_W+1)'(N))
      sum = sum - (IDX_W+1)'(N);
    idx = sum[IDX_W-1:0];
    for (int k = 0; k < N; k++)
      onehot[k] = any && (idx == IDX_W'(k));
  end

endmodule

// File: rtl/usb_upstream_arbiter.sv
// Round-robin packet arbiter giving one downstream PISO at a time access to
// the upstream transceiver, with inter-packet gap and stall watchdog.
module usb_upstream_arbiter
  import usb_upstream_arbiter_pkg::*;
#(
  parameter int NUM_USB_DEVICES = 2,
  parameter int IPG_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                     clock,
  input  logic                                     reset,
  usb_upstream_arbiter_if.slave                    bus,
  output logic [`WIDTH_TO_RANGE(NUM_USB_DEVICES)]  grant,
  output logic [`CLOG2_WIDTH(NUM_USB_DEVICES)-1:0] grant_idx,
  output logic                                     busy,
  output logic                                     timeout_pulse
);

  localparam int N     = NUM_USB_DEVICES;
  localparam int IDX_W = `CLOG2_WIDTH(NUM_USB_DEVICES);
  localparam int GAP_W = $clog2(IPG_CYCLES + 2);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX      = IDX_W'(N - 1);
  localparam logic [1:0]       AFTER_PACKET = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             seen_val;

  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             g_avail;
  logic             g_val;
  logic             g_last;

  usb_rr_priority_picker #(.N(N), .IDX_W(IDX_W)) picker (
    .req    (bus.piso_serial_data_avail),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // grant is all-zero outside GRANT, so masking with it also blanks the
  // transceiver side during IDLE and GAP.
  assign g_avail = |(bus.piso_serial_data_avail & grant);
  assign g_val   = |(bus.piso_data_val & grant);
  assign g_last  = |(bus.piso_data_last & grant);

  assign bus.tr_data_out          = |(bus.piso_data_out & grant);
  assign bus.tr_data_val          = g_val;
  assign bus.tr_data_last         = g_last;
  assign bus.tr_serial_data_avail = g_avail;
  assign bus.piso_request_serial_data = grant & {N{bus.tr_request_serial_data}};
  assign busy = (state != ST_IDLE);

  always_comb begin
    bus.piso_request_serial_data_type = '0;
    for (int k = 0; k < N; k++)
      if (grant[k])
        bus.piso_request_serial_data_type[k*RT_W +: RT_W] = bus.tr_request_serial_data_type;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      grant         <= '0;
      grant_idx     <= '0;
      rr_ptr        <= '0;
      gap_cnt       <= '0;
      wd_cnt        <= '0;
      seen_val      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_GRANT;
            grant     <= pick_onehot;
            grant_idx <= pick_idx;
            rr_ptr    <= (pick_idx == IDX_MAX) ? '0 : pick_idx + 1'b1;
            wd_cnt    <= '0;
            seen_val  <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Completion is checked first so a last bit on the timeout cycle wins.
          if (g_val && g_last) begin
            grant   <= '0;
            gap_cnt <= '0;
            state   <= AFTER_PACKET;
          end else if (!g_avail && !seen_val && !g_val && !bus.tr_request_serial_data) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (g_val || bus.tr_request_serial_data) begin
            wd_cnt   <= '0;
            seen_val <= seen_val | g_val;
          end else if (wd_cnt == WD_LAST) begin
            grant         <= '0;
            gap_cnt       <= '0;
            timeout_pulse <= 1'b1;
            state         <= AFTER_PACKET;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
